rx_ctrl: RTL

RX_CTRL -- requirements
Module: rx_ctrl

---
 rtl/rx_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rx_ctrl.sv
// UART-style serial receiver: 2-flop input synchronizer, mid-bit sampling FSM
// and a single-entry valid/ready output buffer with frame-error and overrun pulses.
module rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BW      = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_i,
    output logic [DATA_BW-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               frameErr_o,
    output logic               overrun_o,
    output logic               busy_o
);

    localparam int SCW = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(DATA_BW + 1);

    localparam logic [SCW-1:0] HALF_M1  = SCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SCW-1:0] FULL_M1  = SCW'(CLKS_PER_BIT - 1);
    localparam logic [SCW-1:0] SMP_ONE  = SCW'(1);
    localparam logic [SCW-1:0] SMP_ZERO = SCW'(0);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BW - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [BCW-1:0] BIT_ZERO = BCW'(0);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [1:0]         sync_q;
    logic               rx_s;
    logic [2:0]         state_q,     state_d;
    logic [SCW-1:0]     smp_cnt_q,   smp_cnt_d;
    logic [BCW-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DATA_BW-1:0] shift_q,     shift_d;
    logic [DATA_BW-1:0] data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q,   overrun_d;
    logic               busy_q,      busy_d;
    logic               xfer_s;

    assign rx_s   = sync_q[1];
    assign xfer_s = valid_q & ready_i;

    // Next-state logic for the receive FSM and the output buffer
    always_comb begin
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE: begin
                smp_cnt_d = SMP_ZERO;
                bit_cnt_d = BIT_ZERO;
                if (!rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // A start bit that is gone by mid-bit is treated as a glitch
                if (smp_cnt_q == HALF_M1) begin
                    smp_cnt_d = SMP_ZERO;
                    bit_cnt_d = BIT_ZERO;
                    if (!rx_s) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q + SMP_ONE;
                end
            end
            S_DATA: begin
                if (smp_cnt_q == FULL_M1) begin
                    smp_cnt_d = SMP_ZERO;
                    shift_d   = {rx_s, shift_q[DATA_BW-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = BIT_ZERO;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q + SMP_ONE;
                end
            end
            S_STOP: begin
                if (smp_cnt_q == FULL_M1) begin
                    smp_cnt_d = SMP_ZERO;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        // A consumer draining the buffer this cycle makes room for the new frame
                        if (!valid_q || ready_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q + SMP_ONE;
                end
            end
            S_WAIT_IDLE: begin
                smp_cnt_d = SMP_ZERO;
                bit_cnt_d = BIT_ZERO;
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                smp_cnt_d = SMP_ZERO;
                bit_cnt_d = BIT_ZERO;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, synchronizer and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            smp_cnt_q   <= SMP_ZERO;
            bit_cnt_q   <= BIT_ZERO;
            shift_q     <= {DATA_BW{1'b0}};
            data_q      <= {DATA_BW{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx_i};
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign frameErr_o = frame_err_q;
    assign overrun_o  = overrun_q;
    assign busy_o     = busy_q;

endmodule
